soc_system_ram_reader: RTL and testbench

//  Avalon-MM read master that fetches 32-bit words from the on-chip RAM slave and

---
 rtl/soc_system_ram_reader_pkg.sv | 25 ++
 rtl/soc_system_ram_reader_if.sv | 28 ++
 rtl/soc_system_ram_reader_fifo.sv | 58 +++++
 rtl/soc_system_ram_reader.sv | 164 ++++++++++++++++
 tb/tb_soc_system_ram_reader.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_system_ram_reader_pkg.sv
// rtl/soc_system_ram_reader_pkg.sv - shared types and widths for the RAM reader
package soc_system_ram_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int DEF_ADDR_W     = 13;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_PEND   = 4;
    localparam int DEF_FIFO_DEPTH = 8;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Counter widths sized for the default configuration above.
    localparam int PEND_W = cnt_width(DEF_MAX_PEND);
    localparam int CNT_W  = cnt_width(DEF_FIFO_DEPTH);

endpackage

// File: rtl/soc_system_ram_reader_if.sv
// rtl/soc_system_ram_reader_if.sv - Avalon-MM read port plus Avalon-ST output bundle
interface soc_system_ram_reader_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0]   m_address;
    logic                m_read;
    logic [DATA_W/8-1:0] m_byteenable;
    logic                m_waitrequest;
    logic [DATA_W-1:0]   m_readdata;
    logic                m_readdatavalid;

    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;

    modport master (
        output m_address, m_read, m_byteenable, st_data, st_valid,
        input  m_waitrequest, m_readdata, m_readdatavalid, st_ready
    );

    modport slave (
        input  m_address, m_read, m_byteenable, st_data, st_valid,
        output m_waitrequest, m_readdata, m_readdatavalid, st_ready
    );

endinterface

// File: rtl/soc_system_ram_reader_fifo.sv
// rtl/soc_system_ram_reader_fifo.sv - first-word-fall-through sample FIFO with clear
module soc_system_ram_reader_fifo
    import soc_system_ram_reader_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              clr,
    input  logic                              wr,
    input  logic [DATA_W-1:0]                 wdata,
    input  logic                              rd,
    output logic [DATA_W-1:0]                 rdata,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic              do_wr;
    logic              do_rd;

    assign empty = (count_q == '0);
    assign do_rd = rd && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr = wr && ((count_q != CW'(FIFO_DEPTH)) || do_rd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wr_ptr] <= wdata;
    end

    // Head is forced to zero when empty so st_data reads 0 out of reset.
    assign rdata = empty ? '0 : mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/soc_system_ram_reader.sv
// rtl/soc_system_ram_reader.sv - Avalon-MM RAM read master streaming words out on Avalon-ST
module soc_system_ram_reader
    import soc_system_ram_reader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_PEND   = DEF_MAX_PEND,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       num_words,
    input  logic                  loop_en,
    output logic                  busy,
    output logic                  done,
    soc_system_ram_reader_if.master bus
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     num_q;
    logic                loop_q;
    logic [PEND_W-1:0]   pend_q;
    logic                stall_q;
    logic                done_q, done_d;
    logic                load;
    logic                rd_req;
    logic                fifo_clr;
    logic                credit;
    logic                accept;
    logic                ret;
    logic                fifo_wr;
    logic                fifo_rd;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [DATA_W-1:0]   fifo_rdata;

    assign accept = bus.m_read && !bus.m_waitrequest;
    assign ret    = bus.m_readdatavalid && (pend_q != '0);

    // Every outstanding read owns a FIFO slot, so returns can never overflow it.
    assign credit = ((int'(pend_q) + int'(fifo_count)) < FIFO_DEPTH) &&
                    (int'(pend_q) < MAX_PEND);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        issued_d = issued_q;
        done_d   = 1'b0;
        load     = 1'b0;
        rd_req   = 1'b0;
        fifo_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    load     = 1'b1;
                    addr_d   = base_addr;
                    issued_d = '0;
                    if (num_words == '0) done_d  = 1'b1;
                    else                 state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A stalled request stays on the bus even across abort.
                rd_req = stall_q || (credit && !abort);
                if (accept) begin
                    if ((issued_q + 1'b1) == num_q) begin
                        if (loop_q) begin
                            addr_d   = base_q;
                            issued_d = '0;
                        end else begin
                            addr_d   = addr_q + 1'b1;
                            issued_d = issued_q + 1'b1;
                            state_d  = ST_DRAIN;
                        end
                    end else begin
                        addr_d   = addr_q + 1'b1;
                        issued_d = issued_q + 1'b1;
                    end
                end
                if (abort) begin
                    state_d  = ST_FLUSH;
                    fifo_clr = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_d  = ST_FLUSH;
                    fifo_clr = 1'b1;
                end else if ((pend_q == '0) && fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                rd_req   = stall_q;
                fifo_clr = 1'b1;
                if ((pend_q == '0) && !stall_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            issued_q <= '0;
            base_q   <= '0;
            num_q    <= '0;
            loop_q   <= 1'b0;
            pend_q   <= '0;
            stall_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            stall_q  <= bus.m_read && bus.m_waitrequest;
            pend_q   <= pend_q + PEND_W'(accept) - PEND_W'(ret);
            if (load) begin
                base_q <= base_addr;
                num_q  <= num_words;
                loop_q <= loop_en;
            end
        end
    end

    assign fifo_wr = bus.m_readdatavalid && (state_q != ST_FLUSH);
    assign fifo_rd = bus.st_valid && bus.st_ready;

    soc_system_ram_reader_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (fifo_clr),
        .wr      (fifo_wr),
        .wdata   (bus.m_readdata),
        .rd      (fifo_rd),
        .rdata   (fifo_rdata),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign busy             = (state_q != ST_IDLE);
    assign done             = done_q;
    assign bus.m_address    = addr_q;
    assign bus.m_read       = rd_req;
    assign bus.m_byteenable = '1;
    assign bus.st_valid     = !fifo_empty;
    assign bus.st_data      = fifo_rdata;

endmodule

// File: tb/tb_soc_system_ram_reader.sv
// tb/tb_soc_system_ram_reader.sv - scoreboard bench for the RAM reader
module tb_soc_system_ram_reader;
    import soc_system_ram_reader_pkg::*;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int MPEND = 4;
    localparam int DEPTH = 8;
    localparam int MEMSZ = 8192;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, loop_en;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          busy, done;

    soc_system_ram_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    soc_system_ram_reader #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MPEND), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (rst_n),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .num_words (num_words),
        .loop_en   (loop_en),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; int due; } rsp_t;

    logic [DW-1:0] mem [MEMSZ];
    logic [DW-1:0] exp_q [$];
    rsp_t          rsp_q [$];
    int n_cmp = 0, n_bad = 0;
    int t_base = 0, t_num = 0, acc_k = 0, outstanding = 0, cyc = 0;
    bit t_loop = 0;
    int wait_pct = 0, lat_min = 1, lat_max = 1, ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave: RAM with random stall and in-order returns after 1..3 cycles.
    initial begin : slave
        logic          prev_stall;
        logic [AW-1:0] prev_addr;
        int            last_due;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdatavalid = 1'b0;
        bus.m_readdata      = '0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        last_due   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rsp_q.delete();
                prev_stall  = 1'b0;
                outstanding = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_read_held", bus.m_read, 1);
                    check("stall_addr_held", bus.m_address, prev_addr);
                end
                if (bus.m_read && !bus.m_waitrequest) begin
                    rsp_t r;
                    int   a;
                    a = (t_base + (t_loop ? acc_k % t_num : acc_k)) % MEMSZ;
                    check("rd_addr", bus.m_address, a);
                    if (!t_loop) check("rd_within_count", acc_k < t_num, 1);
                    r.data = mem[bus.m_address];
                    r.due  = cyc + $urandom_range(lat_max, lat_min);
                    if (rsp_q.size() != 0 && r.due <= last_due) r.due = last_due + 1;
                    last_due = r.due;
                    rsp_q.push_back(r);
                    acc_k++;
                    outstanding++;
                    check("pend_limit", outstanding <= MPEND, 1);
                end
                prev_stall = bus.m_read && bus.m_waitrequest;
                prev_addr  = bus.m_address;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
                bus.m_readdatavalid = 1'b1;
                bus.m_readdata      = rsp_q[0].data;
                void'(rsp_q.pop_front());
                outstanding--;
            end else begin
                bus.m_readdatavalid = 1'b0;
                bus.m_readdata      = $urandom;
            end
            bus.m_waitrequest = ($urandom_range(99) < wait_pct);
        end
    end

    initial begin : ready_drv
        bus.st_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.st_ready = 1'b1;
                1:       bus.st_ready = 1'b0;
                default: bus.st_ready = ($urandom_range(1) == 1);
            endcase
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && bus.st_valid && bus.st_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL st_unexpected: got %0h expected no word at %0t", bus.st_data, $time);
                end else begin
                    check("st_data", bus.st_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic launch(input int b, input int n, input bit lp);
        t_base = b;
        t_num  = n;
        t_loop = lp;
        acc_k  = 0;
        for (int k = 0; k < (lp ? 200 : n); k++)
            exp_q.push_back(mem[(b + (lp ? k % n : k)) % MEMSZ]);
        base_addr = AW'(b);
        num_words = (AW+1)'(n);
        loop_en   = lp;
        start     = 1'b1;
    endtask

    task automatic go(input int b, input int n, input bit lp);
        launch(b, n, lp);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("done_seen", got, 1);
        if (got) begin
            check("busy_at_done", busy, 0);
            @(negedge clk);
            check("done_one_pulse", done, 0);
        end
        check("all_delivered", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_read"}, bus.m_read, 0);
        check({tag, "_m_address"}, bus.m_address, 0);
        check({tag, "_byteenable"}, bus.m_byteenable, 4'hF);
        check({tag, "_st_valid"}, bus.st_valid, 0);
        check({tag, "_st_data"}, bus.st_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int  lat, gaps;
        bit  seen;
        for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        base_addr = '0; num_words = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Straight 4-word read with first-word latency measurement.
        launch(32'h100, 4, 1'b0);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            @(negedge clk);
            if (bus.st_valid) seen = 1'b1;
        end
        check("first_word_latency", lat, 3);
        @(posedge clk);
        #1;
        wait_done(200);

        // Address wrap past the top of RAM.
        go(32'h1FFE, 4, 1'b0);
        wait_done(200);

        // Backpressure: only FIFO_DEPTH reads may be in flight or buffered.
        ready_mode = 1;
        @(posedge clk);
        #1;
        go(32'h0A00, 20, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check("held_read_count", acc_k, DEPTH);
        check("held_m_read_low", bus.m_read, 0);
        base_addr = 13'h0055;
        num_words = 14'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ready_mode = 0;
        wait_done(400);

        // Random stall, return latency and backpressure.
        for (int r = 0; r < 2; r++) begin
            wait_pct = 50; lat_min = 1; lat_max = 3; ready_mode = 2;
            go($urandom_range(MEMSZ - 1), 40 + $urandom_range(20), 1'b0);
            wait_done(3000);
        end
        wait_pct = 0; lat_min = 1; lat_max = 1; ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;

        // Loop replay without gaps, then abort.
        go(32'h1FFF, 3, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.st_valid) seen = 1'b1;
        end
        check("loop_first_valid", seen, 1);
        gaps = 0;
        repeat (30) begin
            @(negedge clk);
            if (!bus.st_valid) gaps++;
        end
        check("loop_gap_count", gaps, 0);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        check("abort_fifo_cleared", bus.st_valid, 0);
        wait_done(100);

        // Abort while idle is ignored.
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_done", done, 0);

        // Zero-length transfer.
        go(32'h0200, 0, 1'b0);
        check("zero_len_done", done, 1);
        check("zero_len_busy", busy, 0);
        @(posedge clk);
        #1;
        check("zero_len_done_clear", done, 0);
        repeat (5) @(posedge clk);
        #1;
        check("zero_len_no_reads", acc_k, 0);

        // Asynchronous reset in the middle of a transfer.
        go(32'h0300, 100, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        exp_q.delete();
        t_num = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after reset.
        go(32'h1234, 6, 1'b0);
        wait_done(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
